// File: rtl/ccff_config_loader_if.sv
// Config-word write port: valid/ready handshake carrying one WORD_W-bit word per transfer.
// The master sources words; the slave (the loader) drives wr_ready.
interface ccff_config_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/ccff_config_loader.sv
// CCFF segment programmer: serialises config words LSB-first into the chain, optionally
// recirculates once comparing CRC-8 of head vs tail, and gates cfg_en until the load is good.
module ccff_config_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter bit VERIFY    = 1'b1
) (
  input  logic                 prog_clk,
  input  logic                 pReset_n,
  input  logic                 start,
  ccff_config_loader_if.slave  wr,
  output logic                 ccff_head,
  output logic                 ccff_shift_en,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cfg_en,
  output logic                 cfg_en_b
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BC_W  = $clog2(WORD_W + 1);
  localparam int CW    = (CNT_W > BC_W) ? CNT_W : BC_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BC_W-1:0]   buf_cnt_q, buf_cnt_d;
  logic [7:0]        crc_l_q, crc_l_d;
  logic [7:0]        crc_v_q, crc_v_d;
  logic              done_q, err_q, cfg_en_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic d);
    logic fb;
    fb = crc[7] ^ d;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  logic [CW-1:0] rem_w, bufc_w, avail_w;
  logic [BC_W-1:0] new_cnt;
  logic take, shift_load, shift_ver;

  assign rem_w   = CW'(CHAIN_LEN) - CW'(bit_cnt_q);
  assign bufc_w  = CW'(buf_cnt_q);
  assign avail_w = rem_w - bufc_w;
  // Last word is truncated to exactly the bits the chain still needs.
  assign new_cnt = (avail_w > CW'(WORD_W)) ? BC_W'(WORD_W) : BC_W'(avail_w);

  assign wr.wr_ready = (state_q == S_LOAD) && (buf_cnt_q <= BC_W'(1)) && (rem_w > bufc_w);
  assign take        = wr.wr_ready && wr.wr_valid;
  assign shift_load  = (state_q == S_LOAD) && (buf_cnt_q != '0);
  assign shift_ver   = (state_q == S_VERIFY) && (vcnt_q != CNT_W'(CHAIN_LEN));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    vcnt_d        = vcnt_q;
    buf_d         = buf_q;
    buf_cnt_d     = buf_cnt_q;
    crc_l_d       = crc_l_q;
    crc_v_d       = crc_v_q;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          vcnt_d    = '0;
          buf_d     = '0;
          buf_cnt_d = '0;
          crc_l_d   = '0;
          crc_v_d   = '0;
        end
      end
      S_LOAD: begin
        if (shift_load) begin
          ccff_shift_en = 1'b1;
          ccff_head     = buf_q[0];
          buf_d         = buf_q >> 1;
          buf_cnt_d     = buf_cnt_q - BC_W'(1);
          bit_cnt_d     = bit_cnt_q + CNT_W'(1);
          crc_l_d       = crc8_step(crc_l_q, buf_q[0]);
        end
        if (take) begin
          buf_d     = wr.wr_data;
          buf_cnt_d = new_cnt;
        end
        // Leave LOAD on the edge that shifts the final bit so VERIFY follows with no bubble.
        if (shift_load && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1))) begin
          state_d = VERIFY ? S_VERIFY : S_DONE;
          vcnt_d  = '0;
        end
      end
      S_VERIFY: begin
        if (shift_ver) begin
          ccff_shift_en = 1'b1;
          ccff_head     = ccff_tail;
          crc_v_d       = crc8_step(crc_v_q, ccff_tail);
          vcnt_d        = vcnt_q + CNT_W'(1);
        end else begin
          state_d = (crc_v_q == crc_l_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      vcnt_q    <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      crc_l_q   <= '0;
      crc_v_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cfg_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      vcnt_q    <= vcnt_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      crc_l_q   <= crc_l_d;
      crc_v_q   <= crc_v_d;
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_d == S_ERR);
      cfg_en_q  <= (state_d == S_DONE);
    end
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign done     = done_q;
  assign err      = err_q;
  assign cfg_en   = cfg_en_q;
  assign cfg_en_b = ~cfg_en_q;

endmodule

// File: tb/tb_ccff_config_loader.sv
// Directed bench for ccff_config_loader with a 20-flop behavioural chain on head/tail.
module tb_ccff_config_loader;

  localparam int N = 20;

  logic prog_clk = 1'b0;
  logic pReset_n = 1'b0;
  logic start    = 1'b0;
  logic ccff_head, ccff_shift_en, ccff_tail;
  logic busy, done, err, cfg_en, cfg_en_b;

  ccff_config_loader_if #(.WORD_W(8)) ifc ();

  ccff_config_loader #(.CHAIN_LEN(N), .WORD_W(8), .VERIFY(1'b1)) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .wr            (ifc),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cfg_en        (cfg_en),
    .cfg_en_b      (cfg_en_b)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: flop 0 takes head, flop N-1 drives tail.
  logic [N-1:0] chain = '0;
  bit inject = 1'b0;
  int cyc = 0, sh_total = 0, run = 0, max_run = 0, stall_cnt = 0, done_cyc = 0;
  bit done_seen = 1'b0, mon_clr = 1'b0;

  assign ccff_tail = chain[N-1];

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (ccff_shift_en)
      chain <= {chain[N-2:0], ccff_head} ^ ((inject && sh_total == 25) ? 20'h00400 : 20'h0);
  end

  always @(negedge prog_clk) begin
    if (mon_clr) begin
      sh_total <= 0; run <= 0; max_run <= 0; stall_cnt <= 0; done_seen <= 1'b0; done_cyc <= 0;
    end else begin
      if (ccff_shift_en) begin
        sh_total <= sh_total + 1;
        run      <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
      end else begin
        run <= 0;
        if (busy) stall_cnt <= stall_cnt + 1;
      end
      if ((done || err) && !done_seen) begin
        done_seen <= 1'b1;
        done_cyc  <= cyc;
      end
    end
  end

  int n_checks = 0, n_pass = 0;
  int e0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] outs();
    return {ifc.wr_ready, ccff_head, ccff_shift_en, busy, done, err, cfg_en, cfg_en_b};
  endfunction

  task automatic pulse_start();
    @(posedge prog_clk); #1;
    start = 1'b1; mon_clr = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0; mon_clr = 1'b0;
    e0 = cyc;
  endtask

  // Offers one word; gap>0 waits for ready then idles gap cycles before offering.
  task automatic push_word(input logic [7:0] w, input int gap, input int bound, output bit ok);
    ok = 1'b0;
    if (gap > 0) begin
      ifc.wr_valid = 1'b0;
      for (int t = 0; t < bound; t++) begin
        @(negedge prog_clk);
        if (ifc.wr_ready) break;
      end
      repeat (gap) @(posedge prog_clk);
      #1;
    end
    ifc.wr_data  = w;
    ifc.wr_valid = 1'b1;
    for (int t = 0; t < bound; t++) begin
      @(negedge prog_clk);
      if (ifc.wr_ready) begin
        ok = 1'b1;
        @(posedge prog_clk); #1;
        break;
      end
    end
  endtask

  task automatic wait_end(input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge prog_clk);
      if (done || err) begin seen = 1'b1; break; end
    end
    #1;
    check({tag, "_finished"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap, input bit inj,
                          input bit exp_err, input logic [N-1:0] exp_chain);
    bit ok;
    inject = inj;
    pulse_start();
    push_word(w0, 0, 60, ok);   check({tag, "_acc0"}, {31'd0, ok}, 32'd1);
    push_word(w1, gap, 60, ok); check({tag, "_acc1"}, {31'd0, ok}, 32'd1);
    push_word(w2, gap, 60, ok); check({tag, "_acc2"}, {31'd0, ok}, 32'd1);
    if (gap == 0) begin
      push_word(8'hFF, 0, 30, ok);
      check({tag, "_extra_word_refused"}, {31'd0, ok}, 32'd0);
    end
    ifc.wr_valid = 1'b0;
    wait_end(tag);
    check({tag, "_status"}, {24'd0, outs()},
          exp_err ? 32'h0000_0005 : 32'h0000_000A);
    check({tag, "_shift_total"}, sh_total, 2 * N);
    if (gap == 0) begin
      check({tag, "_latency"}, done_cyc - e0, 2 * N + 2);
      check({tag, "_shift_run"}, max_run, 2 * N);
      check({tag, "_stalls"}, stall_cnt, 2);
    end else begin
      check({tag, "_gap_stalls"}, {31'd0, stall_cnt > 2}, 32'd1);
    end
    if (!exp_err) check({tag, "_chain"}, {12'd0, chain}, {12'd0, exp_chain});
    inject = 1'b0;
  endtask

  initial begin
    bit ok;
    bit hit;
    ifc.wr_data  = '0;
    ifc.wr_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge prog_clk);
    check("reset_outs", {24'd0, outs()}, 32'h0000_0001);
    pReset_n = 1'b1;
    repeat (2) @(negedge prog_clk);
    check("idle_outs", {24'd0, outs()}, 32'h0000_0001);

    // Streaming load, chain = bitrev(0xF3CA5)
    run_load("load", 8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0, 20'hA53CF);

    // Bit flip during recirculation
    run_load("crcerr", 8'hA5, 8'h3C, 8'h0F, 0, 1'b1, 1'b1, 20'h0);

    // Gapped writer, chain = bitrev(0x63412)
    run_load("gaps", 8'h12, 8'h34, 8'h56, 3, 1'b0, 1'b0, 20'h482C6);

    // Reset mid-LOAD
    pulse_start();
    push_word(8'hA5, 0, 60, ok);
    ifc.wr_valid = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge prog_clk);
      if (sh_total >= 7) begin hit = 1'b1; break; end
    end
    check("midload_reached", {31'd0, hit}, 32'd1);
    check("midload_busy", {31'd0, busy}, 32'd1);
    pReset_n = 1'b0;
    #1;
    check("midload_reset_outs", {24'd0, outs()}, 32'h0000_0001);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    run_load("reload", 8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0, 20'hA53CF);

    // start ignored while loading
    pulse_start();
    push_word(8'hA5, 0, 60, ok);
    ifc.wr_data = 8'h3C;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    push_word(8'h3C, 0, 60, ok);
    push_word(8'h0F, 0, 60, ok);
    ifc.wr_valid = 1'b0;
    wait_end("restart_ign");
    check("restart_ign_latency", done_cyc - e0, 2 * N + 2);
    check("restart_ign_chain", {12'd0, chain}, 32'h000A_53CF);

    // start from DONE drops cfg_en immediately and reloads
    pulse_start();
    check("redo_outs", {24'd0, outs()}, 32'h0000_0091);
    push_word(8'h12, 0, 60, ok);
    push_word(8'h34, 0, 60, ok);
    push_word(8'h56, 0, 60, ok);
    ifc.wr_valid = 1'b0;
    wait_end("redo");
    check("redo_status", {24'd0, outs()}, 32'h0000_000A);
    check("redo_chain", {12'd0, chain}, 32'h0004_82C6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
